// File: rtl/el2_pmp_chan_arb_pkg.sv
// rtl/el2_pmp_chan_arb_pkg.sv - shared types and helpers for the PMP channel arbiter
package el2_pmp_chan_arb_pkg;

  localparam int PMP_ADDR_W = 32;

  typedef enum logic [1:0] {
    READ  = 2'b01,
    WRITE = 2'b10,
    EXEC  = 2'b11
  } el2_pmp_type_pkt_t;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_CHECK = 2'd1,
    ARB_RESP  = 2'd2
  } el2_pmp_arb_state_e;

  // Requester index width; a single bit is kept even for degenerate counts.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/el2_pmp_chan_arb_if.sv
// rtl/el2_pmp_chan_arb_if.sv - request/response bundle between requesters and the PMP channel arbiter
interface el2_pmp_chan_arb_if #(
  parameter int NUM_REQ = 3,
  parameter int ID_W    = el2_pmp_chan_arb_pkg::id_width(NUM_REQ)
) ();
  import el2_pmp_chan_arb_pkg::*;

  logic [NUM_REQ-1:0]                 req_valid;
  logic [NUM_REQ-1:0]                 req_ready;
  logic [NUM_REQ-1:0][PMP_ADDR_W-1:0] req_addr;
  el2_pmp_type_pkt_t [NUM_REQ-1:0]    req_type;

  logic                               rsp_valid;
  logic [ID_W-1:0]                    rsp_id;
  logic                               rsp_err;
  logic                               rsp_ready;

  modport master (
    output req_valid, req_addr, req_type, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, req_type, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_err
  );

endinterface

// File: rtl/el2_pmp_chan_arb_rr_pick.sv
// rtl/el2_pmp_chan_arb_rr_pick.sv - combinational round-robin picker starting after rr_ptr
module el2_pmp_rr_pick #(
  parameter int NUM_REQ = 3,
  parameter int ID_W    = el2_pmp_chan_arb_pkg::id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    idx,
  output logic               any
);

  // Two passes: indices above rr_ptr first, then the wrap-around from 0 up to rr_ptr.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!any && req[i] && (i > int'(rr_ptr))) begin
        any      = 1'b1;
        grant[i] = 1'b1;
        idx      = ID_W'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!any && req[i] && (i <= int'(rr_ptr))) begin
        any      = 1'b1;
        grant[i] = 1'b1;
        idx      = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/el2_pmp_chan_arb.sv
// rtl/el2_pmp_chan_arb.sv - round-robin sharing of one PMP check channel; RV_PMP_ARB_ERRCNT_EN adds a fault counter
module el2_pmp_chan_arb
  import el2_pmp_chan_arb_pkg::*;
#(
  parameter int NUM_REQ  = 3,
  parameter int ID_W     = id_width(NUM_REQ)
`ifdef RV_PMP_ARB_ERRCNT_EN
  ,
  parameter int ERRCNT_W = 8
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  el2_pmp_chan_arb_if.slave     bus,
  output logic [PMP_ADDR_W-1:0] pmp_chan_addr,
  output el2_pmp_type_pkt_t     pmp_chan_type,
  input  logic                  pmp_chan_err,
  input  logic                  pmp_cfg_wr
`ifdef RV_PMP_ARB_ERRCNT_EN
  ,
  output logic [ERRCNT_W-1:0]   err_count
`endif
);

  el2_pmp_arb_state_e      state_q, state_d;
  logic [ID_W-1:0]         rr_ptr_q;
  logic [PMP_ADDR_W-1:0]   chan_addr_q;
  el2_pmp_type_pkt_t       chan_type_q;
  logic [ID_W-1:0]         rsp_id_q;
  logic                    rsp_valid_q;
  logic                    rsp_err_q;

  logic [NUM_REQ-1:0]      pick_grant;
  logic [ID_W-1:0]         pick_idx;
  logic                    pick_any;
  logic                    arb_en;
  logic                    accept;
  logic                    check_done;
  logic [PMP_ADDR_W-1:0]   sel_addr;
  logic [1:0]              sel_type;

  el2_pmp_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req    (bus.req_valid),
    .rr_ptr (rr_ptr_q),
    .grant  (pick_grant),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  // One-hot mux of the winning request; avoids a variable index into the request arrays.
  always_comb begin
    sel_addr = '0;
    sel_type = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_addr = sel_addr | (bus.req_addr[i] & {PMP_ADDR_W{pick_grant[i]}});
      sel_type = sel_type | (bus.req_type[i] & {2{pick_grant[i]}});
    end
  end

  always_comb begin
    state_d = state_q;
    arb_en  = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        arb_en = 1'b1;
        if (pick_any) state_d = ARB_CHECK;
      end
      ARB_CHECK: begin
        if (!pmp_cfg_wr) state_d = ARB_RESP;
      end
      ARB_RESP: begin
        if (bus.rsp_ready) begin
          arb_en  = 1'b1;
          state_d = pick_any ? ARB_CHECK : ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  assign accept        = arb_en & pick_any;
  // A CSR write in the check cycle makes the channel result stale, so it is not captured.
  assign check_done    = (state_q == ARB_CHECK) && !pmp_cfg_wr;
  assign bus.req_ready = arb_en ? pick_grant : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ARB_IDLE;
      rr_ptr_q    <= ID_W'(NUM_REQ - 1);
      chan_addr_q <= '0;
      chan_type_q <= READ;
      rsp_id_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        chan_addr_q <= sel_addr;
        chan_type_q <= el2_pmp_type_pkt_t'(sel_type);
        rsp_id_q    <= pick_idx;
        rr_ptr_q    <= pick_idx;
      end
      if (check_done) begin
        rsp_valid_q <= 1'b1;
        rsp_err_q   <= pmp_chan_err;
      end else if ((state_q == ARB_RESP) && bus.rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_err   = rsp_err_q;
  assign pmp_chan_addr = chan_addr_q;
  assign pmp_chan_type = chan_type_q;

`ifdef RV_PMP_ARB_ERRCNT_EN
  logic [ERRCNT_W-1:0] err_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else if (rsp_valid_q && bus.rsp_ready && rsp_err_q && !(&err_cnt_q)) begin
      err_cnt_q <= err_cnt_q + 1'b1;
    end
  end

  assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_el2_pmp_chan_arb.sv
// tb/tb_el2_pmp_chan_arb.sv - self-checking bench for el2_pmp_chan_arb
module tb_el2_pmp_chan_arb;
  import el2_pmp_chan_arb_pkg::*;

  localparam int NUM_REQ = 3;
  localparam int ID_W    = 2;
`ifdef RV_PMP_ARB_ERRCNT_EN
  localparam int ERRCNT_W = 2;
  logic [ERRCNT_W-1:0] err_count;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [31:0]       pmp_chan_addr;
  el2_pmp_type_pkt_t pmp_chan_type;
  logic              pmp_chan_err;
  logic              pmp_cfg_wr = 1'b0;
  logic              use_model = 1'b1;
  logic              err_drive = 1'b0;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  bit sb_en  = 1'b0;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic            err;
  } exp_t;

  exp_t               sb_q[$];
  int                 grant_log[$];
  int                 accept_cyc[$];
  logic [NUM_REQ-1:0] last_acc = '0;

  el2_pmp_chan_arb_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

  el2_pmp_chan_arb #(
    .NUM_REQ  (NUM_REQ),
    .ID_W     (ID_W)
`ifdef RV_PMP_ARB_ERRCNT_EN
    ,
    .ERRCNT_W (ERRCNT_W)
`endif
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .pmp_chan_addr (pmp_chan_addr),
    .pmp_chan_type (pmp_chan_type),
    .pmp_chan_err  (pmp_chan_err),
    .pmp_cfg_wr    (pmp_cfg_wr)
`ifdef RV_PMP_ARB_ERRCNT_EN
    ,
    .err_count     (err_count)
`endif
  );

  // Reference PMP: fault on address bit 13, or on a write with address bit 4.
  function automatic logic model_err(input logic [31:0] a, input logic [1:0] t);
    return a[13] | ((t == WRITE) & a[4]);
  endfunction

  assign pmp_chan_err = use_model ? model_err(pmp_chan_addr, pmp_chan_type) : err_drive;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    last_acc = '0;
    if (!rst) begin
      checks++;
      if (!$onehot0(bus.req_ready)) begin
        errors++;
        $display("FAIL ready_onehot0: req_ready=%b required at most one bit set", bus.req_ready);
      end
      if (sb_en) begin
        for (int i = 0; i < NUM_REQ; i++) begin
          if (bus.req_valid[i] && bus.req_ready[i]) begin
            e.id  = ID_W'(i);
            e.err = model_err(bus.req_addr[i], bus.req_type[i]);
            sb_q.push_back(e);
            grant_log.push_back(i);
            accept_cyc.push_back(cyc);
          end
        end
        if (bus.rsp_valid && bus.rsp_ready) begin
          checks++;
          if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL sb_rsp: got id=%0d err=%b required no response", bus.rsp_id, bus.rsp_err);
          end else begin
            e = sb_q.pop_front();
            if (bus.rsp_id !== e.id || bus.rsp_err !== e.err) begin
              errors++;
              $display("FAIL sb_rsp: got id=%0d err=%b required id=%0d err=%b",
                       bus.rsp_id, bus.rsp_err, e.id, e.err);
            end
          end
        end
      end
      last_acc = bus.req_valid & bus.req_ready;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic drop_accepted();
    bus.req_valid = bus.req_valid & ~last_acc;
  endtask

  task automatic do_reset();
    tick();
    rst           = 1'b1;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;
    pmp_cfg_wr    = 1'b0;
    use_model     = 1'b1;
    err_drive     = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    sb_q.delete();
    grant_log.delete();
    accept_cyc.delete();
  endtask

  task automatic drain(input int max_cyc);
    bit done;
    done = 1'b0;
    bus.rsp_ready = 1'b1;
    for (int c = 0; c < max_cyc && !done; c++) begin
      tick();
      drop_accepted();
      sample();
      if (sb_q.size() == 0 && !bus.rsp_valid && bus.req_valid == '0) done = 1'b1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL drain: pending=%0d rsp_valid=%b required all responses within %0d cycles",
               sb_q.size(), bus.rsp_valid, max_cyc);
    end
  endtask

  task automatic test_reset();
    sb_en = 1'b0;
    do_reset();
    sample();
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.rsp_id !== '0 || bus.rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_rsp: valid=%b id=%0d err=%b required 0 0 0", bus.rsp_valid, bus.rsp_id, bus.rsp_err);
    end
    checks++;
    if (pmp_chan_addr !== 32'h0 || pmp_chan_type !== READ) begin
      errors++;
      $display("FAIL reset_chan: addr=%h type=%b required 00000000 01", pmp_chan_addr, pmp_chan_type);
    end
`ifdef RV_PMP_ARB_ERRCNT_EN
    checks++;
    if (err_count !== '0) begin
      errors++;
      $display("FAIL reset_errcnt: err_count=%0d required 0", err_count);
    end
`endif
    bus.req_valid = 3'b110;
    #1;
    checks++;
    if (bus.req_ready !== 3'b010) begin
      errors++;
      $display("FAIL reset_rr_ptr: req_ready=%b required 010", bus.req_ready);
    end
    bus.req_valid = '0;
  endtask

  task automatic test_single();
    do_reset();
    sb_en           = 1'b1;
    bus.rsp_ready   = 1'b1;
    bus.req_addr[0] = 32'h0000_1000;
    bus.req_type[0] = READ;
    bus.req_valid   = 3'b001;
    sample();
    checks++;
    if (bus.req_ready !== 3'b001) begin
      errors++;
      $display("FAIL single_ready: req_ready=%b required 001", bus.req_ready);
    end
    tick();
    drop_accepted();
    sample();
    checks++;
    if (bus.rsp_valid !== 1'b0 || pmp_chan_addr !== 32'h1000 || pmp_chan_type !== READ) begin
      errors++;
      $display("FAIL single_t1: rsp_valid=%b addr=%h type=%b required 0 00001000 01",
               bus.rsp_valid, pmp_chan_addr, pmp_chan_type);
    end
    tick();
    sample();
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd0 || bus.rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL single_t2: valid=%b id=%0d err=%b required 1 0 0", bus.rsp_valid, bus.rsp_id, bus.rsp_err);
    end
    tick();
    sample();
    checks++;
    if (bus.rsp_valid !== 1'b0 || pmp_chan_addr !== 32'h1000) begin
      errors++;
      $display("FAIL single_idle: rsp_valid=%b addr=%h required 0 00001000", bus.rsp_valid, pmp_chan_addr);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    sb_en           = 1'b1;
    bus.rsp_ready   = 1'b1;
    bus.req_addr[0] = 32'h0000_2000;
    bus.req_type[0] = READ;
    bus.req_addr[1] = 32'h0000_0010;
    bus.req_type[1] = WRITE;
    bus.req_addr[2] = 32'h0000_0100;
    bus.req_type[2] = EXEC;
    bus.req_valid   = 3'b111;
    sample();
    for (int c = 0; c < 40 && grant_log.size() < 6; c++) begin
      tick();
      sample();
    end
    tick();
    bus.req_valid = '0;
    checks++;
    if (grant_log.size() < 6) begin
      errors++;
      $display("FAIL rr_timeout: grants=%0d required 6 within 40 cycles", grant_log.size());
    end else begin
      for (int k = 0; k < 6; k++) begin
        checks++;
        if (grant_log[k] != k % NUM_REQ) begin
          errors++;
          $display("FAIL rr_order: grant %0d went to %0d required %0d", k, grant_log[k], k % NUM_REQ);
        end
      end
      for (int k = 1; k < 6; k++) begin
        checks++;
        if (accept_cyc[k] - accept_cyc[k-1] != 2) begin
          errors++;
          $display("FAIL rr_spacing: accept gap %0d is %0d cycles required 2", k, accept_cyc[k] - accept_cyc[k-1]);
        end
      end
    end
    drain(20);
  endtask

  task automatic test_back_to_back();
    do_reset();
    sb_en           = 1'b1;
    bus.rsp_ready   = 1'b0;
    bus.req_addr[0] = 32'h0000_0000;
    bus.req_type[0] = READ;
    bus.req_valid   = 3'b001;
    sample();
    tick();
    bus.req_addr[1] = 32'h0000_2004;
    bus.req_type[1] = EXEC;
    bus.req_valid   = 3'b010;
    sample();
    checks++;
    if (bus.req_ready !== 3'b000) begin
      errors++;
      $display("FAIL bp_check_ready: req_ready=%b required 000", bus.req_ready);
    end
    tick();
    sample();
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd0 || bus.rsp_err !== 1'b0 || bus.req_ready !== 3'b000) begin
        errors++;
        $display("FAIL bp_hold: cycle %0d valid=%b id=%0d err=%b ready=%b required 1 0 0 000",
                 k, bus.rsp_valid, bus.rsp_id, bus.rsp_err, bus.req_ready);
      end
      tick();
      sample();
    end
    tick();
    bus.rsp_ready = 1'b1;
    sample();
    checks++;
    if (bus.req_ready !== 3'b010) begin
      errors++;
      $display("FAIL bp_accept: req_ready=%b required 010", bus.req_ready);
    end
    tick();
    drop_accepted();
    sample();
    checks++;
    if (bus.rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_drop: rsp_valid=%b required 0", bus.rsp_valid);
    end
    tick();
    sample();
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd1 || bus.rsp_err !== 1'b1) begin
      errors++;
      $display("FAIL bp_second: valid=%b id=%0d err=%b required 1 1 1", bus.rsp_valid, bus.rsp_id, bus.rsp_err);
    end
    drain(10);
  endtask

  task automatic test_cfg_wr();
    do_reset();
    sb_en           = 1'b0;
    use_model       = 1'b0;
    err_drive       = 1'b0;
    bus.rsp_ready   = 1'b1;
    bus.req_addr[2] = 32'h0000_0040;
    bus.req_type[2] = READ;
    bus.req_valid   = 3'b100;
    sample();
    checks++;
    if (bus.req_ready !== 3'b100) begin
      errors++;
      $display("FAIL cfg_ready: req_ready=%b required 100", bus.req_ready);
    end
    tick();
    bus.req_valid = '0;
    pmp_cfg_wr    = 1'b1;
    sample();
    tick();
    err_drive = 1'b1;
    sample();
    checks++;
    if (bus.rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL cfg_stall: rsp_valid=%b at T+2 required 0", bus.rsp_valid);
    end
    tick();
    pmp_cfg_wr = 1'b0;
    sample();
    checks++;
    if (bus.rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL cfg_stall: rsp_valid=%b at T+3 required 0", bus.rsp_valid);
    end
    tick();
    sample();
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b1 || bus.rsp_id !== 2'd2) begin
      errors++;
      $display("FAIL cfg_rsp: valid=%b err=%b id=%0d required 1 1 2", bus.rsp_valid, bus.rsp_err, bus.rsp_id);
    end
    tick();
    use_model = 1'b1;
    sample();
  endtask

  task automatic test_reset_mid();
    do_reset();
    sb_en           = 1'b1;
    bus.rsp_ready   = 1'b0;
    bus.req_addr[1] = 32'h0000_0000;
    bus.req_type[1] = READ;
    bus.req_valid   = 3'b010;
    sample();
    tick();
    bus.req_valid = '0;
    sample();
    tick();
    sample();
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd1) begin
      errors++;
      $display("FAIL rm_resp: valid=%b id=%0d required 1 1", bus.rsp_valid, bus.rsp_id);
    end
    tick();
    rst = 1'b1;
    sample();
    tick();
    rst = 1'b0;
    sb_q.delete();
    grant_log.delete();
    accept_cyc.delete();
    bus.req_addr[0] = 32'h0000_2000;
    bus.req_type[0] = READ;
    bus.req_addr[2] = 32'h0000_0010;
    bus.req_type[2] = WRITE;
    bus.req_valid   = 3'b101;
    bus.rsp_ready   = 1'b1;
    sample();
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.rsp_id !== 2'd0) begin
      errors++;
      $display("FAIL rm_drop: valid=%b id=%0d required 0 0", bus.rsp_valid, bus.rsp_id);
    end
    checks++;
    if (bus.req_ready !== 3'b001) begin
      errors++;
      $display("FAIL rm_restart: req_ready=%b required 001", bus.req_ready);
    end
    drain(20);
  endtask

`ifdef RV_PMP_ARB_ERRCNT_EN
  task automatic test_errcnt();
    int exp_cnt;
    do_reset();
    sb_en           = 1'b1;
    bus.rsp_ready   = 1'b1;
    bus.req_addr[0] = 32'h0000_2000;
    bus.req_type[0] = READ;
    for (int k = 0; k < 5; k++) begin
      bus.req_valid = 3'b001;
      sample();
      tick();
      drop_accepted();
      sample();
      tick();
      sample();
      tick();
      sample();
      exp_cnt = (k + 1 > 3) ? 3 : k + 1;
      checks++;
      if (err_count !== ERRCNT_W'(exp_cnt)) begin
        errors++;
        $display("FAIL errcnt: after fault %0d err_count=%0d required %0d", k + 1, err_count, exp_cnt);
      end
      tick();
    end
  endtask
`endif

  initial begin
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_addr[i] = '0;
      bus.req_type[i] = READ;
    end
    test_reset();
    test_single();
    test_round_robin();
    test_back_to_back();
    test_cfg_wr();
    test_reset_mid();
`ifdef RV_PMP_ARB_ERRCNT_EN
    test_errcnt();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t required completion", $time);
    $fatal(1);
  end

endmodule
